csi_byte_aligner: RTL and testbench
===================================

# csi_byte_aligner

Per-lane MIPI CSI-2 HS byte aligner. It sits directly downstream of the lane deserializer and consumes the raw, arbitrarily bit-shifted 8-bit words it produces on the byte clock. It hunts for the HS sync byte at any of 8 bit offsets, locks that offset for the rest of the HS burst, and emits byte-aligned data to the lane merger.

## Interface
- SYNC_BYTE, 8'hB8, HS sync pattern, LSB-first on the wire.
- MAX_HUNT, 32, bytes allowed in HUNT before a sync-timeout error; legal range 1..255.
- clk  in  1  byte clock (deserializer divided clock).
- rst  in  1  reset, asynchronous, active-high.
- in_en  in  1  lane in HS mode; low = LP/idle, data ignored.
- in_data  in  8  raw deserialized word; bit 0 is the earliest received bit.
- out_valid  out  1  out_data holds an aligned byte.
- out_data  out  8  aligned byte, bit 0 earliest.
- out_sync  out  1  one-cycle pulse, coincident with the out_valid cycle carrying SYNC_BYTE.
- locked  out  1  high while in LOCKED.
- err_sync  out  1  one-cycle pulse on hunt timeout.

## Operation
- prev register holds the previous in_data; window = {in_data, prev} (16 bits, prev in the low half).
- Candidate at offset k (0..7) = window[k+7:k].
- Match at k requires candidate == SYNC_BYTE and window[k-1:0] all zero (HS-zero leader; empty for k=0).
- Lowest matching k wins.
- FSM states IDLE, HUNT, LOCKED, FAIL:
  - IDLE: in_en=1 -> HUNT; clear the hunt counter.
  - HUNT: match -> LOCKED, latch k into off. No match -> counter++. Counter reaching MAX_HUNT -> FAIL with err_sync pulse.
  - LOCKED: every cycle, out_data = window[off+7:off] and out_valid=1.
  - FAIL: no output; wait for in_en=0.
  - Any state with in_en=0 -> IDLE on the next edge. This takes priority over match and timeout in the same cycle.
- prev updates every cycle regardless of state or in_en.
- Residual bits of the final partial byte at burst end are dropped.
- The counter is 8 bits and saturates; it never wraps.

## Timing
- Reset values: state=IDLE, prev=0, off=0, counter=0; out_valid=0, out_data=0, out_sync=0, locked=0, err_sync=0.
- All outputs are registered.
- Latency: match in the cycle where window(t) is present. At t+1 the outputs are out_valid=1, out_sync=1, out_data=SYNC_BYTE, locked=1.
- Each following input cycle t+n produces an output byte at t+n+1.
- in_en falling at t: the t+1 edge enters IDLE. From t+1 on, out_valid=0 and locked=0, and the byte built from window(t) is discarded.
- Timeout: the err_sync pulse occurs on the cycle after the MAX_HUNT-th non-matching HUNT cycle.
- A match in that same cycle takes priority over timeout.
- rst mid-burst: all outputs clear asynchronously. The block restarts from IDLE and re-hunts if in_en is still high.

## Structure
- Shared package csi_pkg holds:
  - CSI_SYNC_BYTE (8'hB8)
  - typedef enum aligner_state_t {IDLE, HUNT, LOCKED, FAIL}
  - typedef logic [2:0] bit_off_t
- Sub-module csi_sync_detect is combinational: window and SYNC_BYTE in; match and bit_off_t out (priority encoder over the 8 offsets).
- The FSM, counter and output registers live in csi_byte_aligner.

## Test plan
- Offset 3: in_en=1, stream 0x00, 0xC0, 0x95, 0x00 -> out_sync with out_data=0xB8, then out_data=0x12, locked=1.
- Offset 0: stream 0x00, 0xB8, 0x34 -> 0xB8 (out_sync), then 0x34. Offsets 1..7 are swept the same way, each giving an identical payload.
- False match rejected: stream 0x00, 0xC4, 0x95 (leader bit 2 set) -> no lock.
- Timeout: MAX_HUNT=4, in_en=1, input 0xFF for 6 cycles -> single err_sync pulse after the 4th cycle, state FAIL, no out_valid until in_en toggles.
- Burst end: locked, then in_en=0 -> next cycle out_valid=0, locked=0. Re-assert in_en with sync at offset 5 -> relock at offset 5.
- Async rst asserted mid-LOCKED between clock edges -> all outputs 0 immediately. Deassert with in_en=1 and a valid sync -> lock again.

Source files
------------

// File: rtl/csi_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | csi_pkg: shared types and constants for the CSI-2 lane aligner     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package csi_pkg;

   localparam logic [7:0] CSI_SYNC_BYTE = 8'hB8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      HUNT   = 2'd1,
      LOCKED = 2'd2,
      FAIL   = 2'd3
   } aligner_state_t;

   typedef logic [2:0] bit_off_t;

   // Bits below a candidate offset must be the HS-zero leader.
   function automatic logic [15:0] lead_mask(input bit_off_t k);
      return (16'd1 << k) - 16'd1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/csi_sync_detect.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | csi_sync_detect: finds the lowest bit offset holding the HS sync   |
// | byte preceded by zeros. Rev 1.0                                    |
// +--------------------------------------------------------------------+
module csi_sync_detect
   import csi_pkg::*;
(
   input  logic [15:0] i_window,
   input  logic [7:0]  i_sync,
   output logic        o_match,
   output bit_off_t    o_off
);

   logic [7:0] w_hit;

   for (genvar k = 0; k < 8; k++) begin : g_off
      assign w_hit[k] = (i_window[k+7:k] == i_sync) &&
                        ((i_window & lead_mask(bit_off_t'(k))) == 16'd0);
   end

   // Scan downward so the lowest matching offset is the last one written.
   always_comb begin
      o_match = 1'b0;
      o_off   = '0;
      for (int k = 7; k >= 0; k--) begin
         if (w_hit[k]) begin
            o_match = 1'b1;
            o_off   = bit_off_t'(k);
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/csi_byte_aligner.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | csi_byte_aligner: per-lane HS byte aligner, hunts sync at 8 bit    |
// | offsets and locks for the burst. Rev 1.0                           |
// +--------------------------------------------------------------------+
module csi_byte_aligner
   import csi_pkg::*;
#(
   parameter logic [7:0]  SYNC_BYTE = CSI_SYNC_BYTE,
   parameter int unsigned MAX_HUNT  = 32
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_en,
   input  logic [7:0] in_data,
   output logic       out_valid,
   output logic [7:0] out_data,
   output logic       out_sync,
   output logic       locked,
   output logic       err_sync
);

   localparam logic [7:0] c_MAX_HUNT = 8'(MAX_HUNT);

   aligner_state_t r_state, w_state_nx;
   logic [7:0]     r_prev;
   bit_off_t       r_off, w_off_nx;
   logic [7:0]     r_cnt, w_cnt_nx, w_cnt_inc;
   logic           r_valid, r_sync, r_locked, r_err;
   logic [7:0]     r_data;
   logic           w_valid_nx, w_sync_nx, w_err_nx;
   logic [7:0]     w_data_nx;
   logic [15:0]    w_window;
   logic           w_match;
   bit_off_t       w_det_off;

   assign w_window  = {in_data, r_prev};
   assign w_cnt_inc = (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;

   csi_sync_detect u_detect (
      .i_window (w_window),
      .i_sync   (SYNC_BYTE),
      .o_match  (w_match),
      .o_off    (w_det_off)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nx;
      end
   end

   always_comb begin
      w_state_nx = r_state;
      w_off_nx   = r_off;
      w_cnt_nx   = r_cnt;
      w_valid_nx = 1'b0;
      w_sync_nx  = 1'b0;
      w_err_nx   = 1'b0;
      w_data_nx  = 8'h00;
      // Leaving HS mode overrides any match or timeout in the same cycle.
      if (!in_en) begin
         w_state_nx = IDLE;
         w_cnt_nx   = 8'h00;
      end else begin
         case (r_state)
            IDLE: begin
               w_state_nx = HUNT;
               w_cnt_nx   = 8'h00;
            end
            HUNT: begin
               if (w_match) begin
                  w_state_nx = LOCKED;
                  w_off_nx   = w_det_off;
                  w_valid_nx = 1'b1;
                  w_sync_nx  = 1'b1;
                  w_data_nx  = SYNC_BYTE;
               end else begin
                  w_cnt_nx = w_cnt_inc;
                  if (w_cnt_inc >= c_MAX_HUNT) begin
                     w_state_nx = FAIL;
                     w_err_nx   = 1'b1;
                  end
               end
            end
            LOCKED: begin
               w_valid_nx = 1'b1;
               w_data_nx  = w_window[r_off +: 8];
            end
            FAIL: begin
               w_state_nx = FAIL;
            end
            default: begin
               w_state_nx = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_prev   <= 8'h00;
         r_off    <= '0;
         r_cnt    <= 8'h00;
         r_valid  <= 1'b0;
         r_data   <= 8'h00;
         r_sync   <= 1'b0;
         r_locked <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_prev   <= in_data;
         r_off    <= w_off_nx;
         r_cnt    <= w_cnt_nx;
         r_valid  <= w_valid_nx;
         r_data   <= w_data_nx;
         r_sync   <= w_sync_nx;
         r_locked <= (w_state_nx == LOCKED);
         r_err    <= w_err_nx;
      end
   end

   assign out_valid = r_valid;
   assign out_data  = r_data;
   assign out_sync  = r_sync;
   assign locked    = r_locked;
   assign err_sync  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_csi_byte_aligner.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_csi_byte_aligner: scoreboard bench for the CSI-2 byte aligner   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_csi_byte_aligner;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_en = 1'b0;
   logic [7:0] in_data = 8'h00;
   logic       out_valid, out_sync, locked, err_sync;
   logic [7:0] out_data;
   logic [11:0] w_obs;

   int n_checks = 0;
   int n_pass   = 0;

   logic        s_en[$];
   logic [7:0]  s_d[$];
   logic [11:0] s_exp[$];
   logic [11:0] exp_q[$];

   csi_byte_aligner #(.SYNC_BYTE(8'hB8), .MAX_HUNT(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_en     (in_en),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_sync  (out_sync),
      .locked    (locked),
      .err_sync  (err_sync)
   );

   always #5 clk = ~clk;

   // {valid, sync, locked, err, data}
   assign w_obs = {out_valid, out_sync, locked, err_sync, out_data};

   function automatic logic [11:0] ev(input logic v, input logic s, input logic l,
                                      input logic e, input logic [7:0] d);
      return {v, s, l, e, d};
   endfunction

   task automatic add(input logic en, input logic [7:0] d, input logic [11:0] e);
      s_en.push_back(en);
      s_d.push_back(d);
      s_exp.push_back(e);
   endtask

   // Sync at bit offset k after a zero leader, then payload p, then zeros.
   task automatic add_burst(input int k, input logic [7:0] p);
      logic [39:0] b;
      b = 40'({p, 8'hB8}) << (8 + k);
      add(1'b1, b[7:0],   12'h000);
      add(1'b1, b[15:8],  12'h000);
      add(1'b1, b[23:16], ev(1, 1, 1, 0, 8'hB8));
      add(1'b1, b[31:24], ev(1, 0, 1, 0, p));
      add(1'b1, b[39:32], ev(1, 0, 1, 0, 8'h00));
   endtask

   task automatic test_reset;
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if (w_obs !== 12'h000) $display("FAIL reset: got %h want %h", w_obs, 12'h000);
      else n_pass++;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_offset3;
      logic [11:0] e;
      int i = 0;
      add(1'b1, 8'h00, 12'h000);
      add(1'b1, 8'hC0, 12'h000);
      add(1'b1, 8'h95, ev(1, 1, 1, 0, 8'hB8));
      add(1'b1, 8'h00, ev(1, 0, 1, 0, 8'h12));
      add(1'b0, 8'h00, 12'h000);
      while (s_en.size() != 0) begin
         @(negedge clk);
         in_en = s_en.pop_front();
         in_data = s_d.pop_front();
         exp_q.push_back(s_exp.pop_front());
         @(posedge clk);
         #1;
         e = exp_q.pop_front();
         n_checks++;
         if (w_obs !== e) $display("FAIL offset3 step %0d: got %h want %h", i, w_obs, e);
         else n_pass++;
         i++;
      end
   endtask

   task automatic test_offset_sweep;
      logic [11:0] e;
      int i = 0;
      for (int k = 0; k < 8; k++) begin
         add_burst(k, 8'h34);
         add(1'b0, 8'h00, 12'h000);
      end
      while (s_en.size() != 0) begin
         @(negedge clk);
         in_en = s_en.pop_front();
         in_data = s_d.pop_front();
         exp_q.push_back(s_exp.pop_front());
         @(posedge clk);
         #1;
         e = exp_q.pop_front();
         n_checks++;
         if (w_obs !== e) $display("FAIL sweep step %0d (offset %0d): got %h want %h", i, i / 6, w_obs, e);
         else n_pass++;
         i++;
      end
   endtask

   // Leader bit 2 set: B8 sits at offset 3 but must be rejected; hunt then times out.
   task automatic test_false_match;
      logic [11:0] e;
      int i = 0;
      add(1'b1, 8'h00, 12'h000);
      add(1'b1, 8'hC4, 12'h000);
      add(1'b1, 8'h95, 12'h000);
      add(1'b1, 8'h00, 12'h000);
      add(1'b1, 8'h00, ev(0, 0, 0, 1, 8'h00));
      add(1'b1, 8'h00, 12'h000);
      add(1'b0, 8'h00, 12'h000);
      while (s_en.size() != 0) begin
         @(negedge clk);
         in_en = s_en.pop_front();
         in_data = s_d.pop_front();
         exp_q.push_back(s_exp.pop_front());
         @(posedge clk);
         #1;
         e = exp_q.pop_front();
         n_checks++;
         if (w_obs !== e) $display("FAIL false_match step %0d: got %h want %h", i, w_obs, e);
         else n_pass++;
         i++;
      end
   endtask

   task automatic test_timeout;
      logic [11:0] e;
      int i = 0;
      for (int j = 0; j < 8; j++)
         add(1'b1, 8'hFF, (j == 4) ? ev(0, 0, 0, 1, 8'h00) : 12'h000);
      add(1'b0, 8'hFF, 12'h000);
      add_burst(6, 8'hC3);
      add(1'b0, 8'h00, 12'h000);
      while (s_en.size() != 0) begin
         @(negedge clk);
         in_en = s_en.pop_front();
         in_data = s_d.pop_front();
         exp_q.push_back(s_exp.pop_front());
         @(posedge clk);
         #1;
         e = exp_q.pop_front();
         n_checks++;
         if (w_obs !== e) $display("FAIL timeout step %0d: got %h want %h", i, w_obs, e);
         else n_pass++;
         i++;
      end
   endtask

   task automatic test_burst_end;
      logic [11:0] e;
      int i = 0;
      add_burst(2, 8'h5A);
      add(1'b0, 8'h77, 12'h000);
      add(1'b0, 8'h00, 12'h000);
      add_burst(5, 8'hA5);
      add(1'b0, 8'h00, 12'h000);
      while (s_en.size() != 0) begin
         @(negedge clk);
         in_en = s_en.pop_front();
         in_data = s_d.pop_front();
         exp_q.push_back(s_exp.pop_front());
         @(posedge clk);
         #1;
         e = exp_q.pop_front();
         n_checks++;
         if (w_obs !== e) $display("FAIL burst_end step %0d: got %h want %h", i, w_obs, e);
         else n_pass++;
         i++;
      end
   endtask

   task automatic test_async_reset;
      logic [11:0] e;
      int i = 0;
      add_burst(1, 8'h3C);
      while (s_en.size() != 0) begin
         @(negedge clk);
         in_en = s_en.pop_front();
         in_data = s_d.pop_front();
         exp_q.push_back(s_exp.pop_front());
         @(posedge clk);
         #1;
         e = exp_q.pop_front();
         n_checks++;
         if (w_obs !== e) $display("FAIL async_rst lock step %0d: got %h want %h", i, w_obs, e);
         else n_pass++;
         i++;
      end
      #2;
      rst = 1'b1;
      #1;
      n_checks++;
      if (w_obs !== 12'h000) $display("FAIL async_rst clear: got %h want %h", w_obs, 12'h000);
      else n_pass++;
      @(negedge clk);
      rst = 1'b0;
      add_burst(7, 8'h81);
      add(1'b0, 8'h00, 12'h000);
      i = 0;
      while (s_en.size() != 0) begin
         @(negedge clk);
         in_en = s_en.pop_front();
         in_data = s_d.pop_front();
         exp_q.push_back(s_exp.pop_front());
         @(posedge clk);
         #1;
         e = exp_q.pop_front();
         n_checks++;
         if (w_obs !== e) $display("FAIL async_rst relock step %0d: got %h want %h", i, w_obs, e);
         else n_pass++;
         i++;
      end
   endtask

   initial begin
      test_reset();
      test_offset3();
      test_offset_sweep();
      test_false_match();
      test_timeout();
      test_burst_end();
      test_async_reset();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: run did not complete, checks %0d passed %0d", n_checks, n_pass);
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
